// File: rtl/k_counter_filter.sv
// Random-walk K-counter loop filter for the all-digital PLL: turns dn_up sense
// into spaced, mutually exclusive one-cycle inc/dec requests for the DCO.
module k_counter_filter #(
  parameter int unsigned K_MAX   = 8,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dn_up,
  input  logic [3:0]       k_sel,
  output logic             inc,
  output logic             dec,
  output logic             ovf,
  output logic [K_MAX-1:0] up_cnt,
  output logic [K_MAX-1:0] dn_cnt
);

  localparam int unsigned   GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);
  localparam logic [3:0]    K_MAX4   = 4'(K_MAX);

  logic [3:0]       k_q, k_d, k_clamp;
  logic [K_MAX-1:0] up_q, up_d, dn_q, dn_d, mask;
  logic [GW-1:0]    gap_q, gap_d;
  logic             inc_q, inc_d, dec_q, dec_d, ovf_q, ovf_d;
  logic             pinc_q, pinc_d, pdec_q, pdec_d;
  logic             carry, borrow;

  always_comb begin
    k_clamp = k_sel;
    if (k_sel == 4'd0) begin
      k_clamp = 4'd1;
    end else if (k_sel > K_MAX4) begin
      k_clamp = K_MAX4;
    end
  end

  assign mask = ~({K_MAX{1'b1}} << k_q);

  always_comb begin
    k_d    = k_q;
    up_d   = up_q;
    dn_d   = dn_q;
    carry  = 1'b0;
    borrow = 1'b0;
    if (!en) begin
      k_d = k_clamp;
      if (k_clamp != k_q) begin
        up_d = '0;
        dn_d = '0;
      end
    end else if (!dn_up) begin
      carry = (up_q == mask);
      up_d  = carry ? '0 : up_q + K_MAX'(1);
    end else begin
      borrow = (dn_q == mask);
      dn_d   = borrow ? '0 : dn_q + K_MAX'(1);
    end
  end

  always_comb begin
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    pinc_d = pinc_q;
    pdec_d = pdec_q;
    ovf_d  = ovf_q;
    gap_d  = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    // An opposite-direction event annihilates a pending pulse, even when the gap is free.
    if (borrow && pinc_q) begin
      pinc_d = 1'b0;
    end else if (carry && pdec_q) begin
      pdec_d = 1'b0;
    end else if (gap_q == '0) begin
      if (pinc_q) begin
        inc_d  = 1'b1;
        gap_d  = GAP_LOAD;
        pinc_d = carry;
      end else if (pdec_q) begin
        dec_d  = 1'b1;
        gap_d  = GAP_LOAD;
        pdec_d = borrow;
      end else if (carry) begin
        inc_d = 1'b1;
        gap_d = GAP_LOAD;
      end else if (borrow) begin
        dec_d = 1'b1;
        gap_d = GAP_LOAD;
      end
    end else begin
      if (carry) begin
        if (pinc_q) ovf_d = 1'b1;
        else        pinc_d = 1'b1;
      end
      if (borrow) begin
        if (pdec_q) ovf_d = 1'b1;
        else        pdec_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= K_MAX4;
      up_q   <= '0;
      dn_q   <= '0;
      gap_q  <= '0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      ovf_q  <= 1'b0;
      pinc_q <= 1'b0;
      pdec_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
      gap_q  <= gap_d;
      inc_q  <= inc_d;
      dec_q  <= dec_d;
      ovf_q  <= ovf_d;
      pinc_q <= pinc_d;
      pdec_q <= pdec_d;
    end
  end

  assign inc    = inc_q;
  assign dec    = dec_q;
  assign ovf    = ovf_q;
  assign up_cnt = up_q;
  assign dn_cnt = dn_q;

endmodule

// File: tb/tb_k_counter_filter.sv
// Directed bench for k_counter_filter: one instance with MIN_GAP=2, one with MIN_GAP=4.
module tb_k_counter_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en, dn_up, en4, dn_up4;
  logic [3:0] k_sel, k_sel4;
  logic       inc, dec, ovf, inc4, dec4, ovf4;
  logic [7:0] up_cnt, dn_cnt, up_cnt4, dn_cnt4;

  int checks = 0;
  int failures = 0;

  k_counter_filter #(.K_MAX(8), .MIN_GAP(2)) dut (
    .clk(clk), .reset(reset), .en(en), .dn_up(dn_up), .k_sel(k_sel),
    .inc(inc), .dec(dec), .ovf(ovf), .up_cnt(up_cnt), .dn_cnt(dn_cnt)
  );

  k_counter_filter #(.K_MAX(8), .MIN_GAP(4)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .dn_up(dn_up4), .k_sel(k_sel4),
    .inc(inc4), .dec(dec4), .ovf(ovf4), .up_cnt(up_cnt4), .dn_cnt(dn_cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1'b0; dn_up = 1'b0; k_sel = 4'd3;
    en4 = 1'b0; dn_up4 = 1'b0; k_sel4 = 4'd0;
    #1 reset = 1'b1;
    #1;
    chk("rst_inc", inc, 0);
    chk("rst_dec", dec, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_up", up_cnt, 0);
    chk("rst_dn", dn_cnt, 0);
    #10 reset = 1'b0;

    // Test 1: k=3, counting up
    tick();
    en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("t1_up", up_cnt, n % 8);
      chk("t1_inc", inc, (n % 8 == 0) ? 1 : 0);
      chk("t1_dec", dec, 0);
    end
    chk("t1_ovf", ovf, 0);

    // Test 2: k=2, counting down
    en = 1'b0; k_sel = 4'd2; dn_up = 1'b1;
    tick();
    chk("t2_clr_up", up_cnt, 0);
    chk("t2_clr_dn", dn_cnt, 0);
    en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("t2_dn", dn_cnt, n % 4);
      chk("t2_dec", dec, (n % 4 == 0) ? 1 : 0);
      chk("t2_inc", inc, 0);
    end

    // Test 3: k=3, dn_up alternating
    en = 1'b0; k_sel = 4'd3; dn_up = 1'b0;
    tick();
    en = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      dn_up = (n % 2 == 0);
      tick();
      chk("t3_inc", inc, (n == 15 || n == 31) ? 1 : 0);
      chk("t3_dec", dec, (n == 17 || n == 33) ? 1 : 0);
    end
    chk("t3_ovf", ovf, 0);
    en = 1'b0; dn_up = 1'b0;

    // Test 4: MIN_GAP=4, k=1, constant up
    k_sel4 = 4'd1;
    tick();
    en4 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk("t4_up", up_cnt4, n % 2);
      chk("t4_inc", inc4, (n == 2 || n == 6 || n == 10) ? 1 : 0);
      chk("t4_ovf", ovf4, (n >= 8) ? 1 : 0);
    end

    // Async reset while inc4 high and a pulse pending
    reset = 1'b1;
    #1;
    chk("ar4_inc", inc4, 0);
    chk("ar4_ovf", ovf4, 0);
    chk("ar4_up", up_cnt4, 0);
    en4 = 1'b0; k_sel4 = 4'd0;
    tick();
    reset = 1'b0;
    tick();
    chk("ar4_pend1", inc4, 0);
    tick();
    chk("ar4_pend2", inc4, 0);

    // Test 5: cancellation (k_sel=0 clamps to 1)
    en4 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      dn_up4 = (n == 5 || n == 6);
      tick();
      chk("t5_inc", inc4, (n == 2 || n == 8) ? 1 : 0);
      chk("t5_dec", dec4, 0);
      chk("t5_dn", dn_cnt4, (n == 5) ? 1 : 0);
      chk("t5_ovf", ovf4, 0);
    end
    en4 = 1'b0;

    // Test 6: k_sel ignored while enabled, reload on en drop, async reset
    k_sel = 4'd2;
    tick();
    chk("t6_clr0", up_cnt, 0);
    en = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      if (n == 3) k_sel = 4'd5;
      tick();
      chk("t6_up", up_cnt, n % 4);
      chk("t6_inc", inc, (n == 4) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk("t6_clr1", up_cnt, 0);
    en = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      chk("t6_up5", up_cnt, n % 32);
      chk("t6_inc5", inc, (n == 32) ? 1 : 0);
    end
    reset = 1'b1;
    #1;
    chk("ar_inc", inc, 0);
    chk("ar_up", up_cnt, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_dec", dec, 0);
    en = 1'b0;
    #3 reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
